if_id_stage: RTL

- Fetch and IF/ID pipeline stage directly upstream of the ID/EX register.
- Owns the fetch address, drives the instruction-memory request handshake and holds the instruction currently in ID.
- Detects load-use hazards against the instruction in EX, stalls fetch and ID, and asserts Nop so ID/EX latches a bubble.
- Applies branch/jump redirects from later stages, flushes ID and squashes any outstanding fetch.

---
 rtl/ifid_pkg.sv | 23 ++
 rtl/if_id_stage_if.sv | 10 +
 rtl/ifid_hazard.sv | 19 +
 rtl/if_id_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ifid_pkg.sv
// Shared types and constants for the IF/ID fetch stage and its hazard logic.
package ifid_pkg;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } ifid_state_e;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam logic [31:0] INS_BUBBLE   = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface if_id_stage_if;
    logic        Ins_req;
    logic [31:0] Imem_addr;
    logic [31:0] Ins_in;
    logic        Ins_ready;

    modport master (output Ins_req, output Imem_addr, input Ins_in, input Ins_ready);
    modport slave  (input Ins_req, input Imem_addr, output Ins_in, output Ins_ready);
endinterface

// File: rtl/ifid_hazard.sv
// Load-use compare of the EX load destination against the ID source registers.
module ifid_hazard
    import ifid_pkg::*;
(
    input  logic       mem_read,
    input  logic       id_valid,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    // Register zero never carries a dependency.
    always_comb begin
        hazard = mem_read & id_valid & (ex_rt != 5'd0) &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch + IF/ID register: owns the fetch PC, handles load-use stalls with a
// one-entry skid buffer and squashes in-flight fetches on redirects.
module if_id_stage
    import ifid_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    if_id_stage_if.master         imem,
    input  logic                  MemR_ID,
    input  logic [4:0]            EX_rfReSel2,
    input  logic                  Branch_taken,
    input  logic [31:0]           Branch_target,
    input  logic                  Jump_taken,
    input  logic [31:0]           Jump_target,
    output logic [31:0]           Ins_ID,
    output logic [31:0]           PC_IDIF,
    output logic                  Valid_ID,
    output logic                  Nop
);

    ifid_state_e state_r,      state_nx_s;
    logic [31:0] fetch_addr_r, fetch_nx_s;
    logic [31:0] pend_addr_r,  pend_nx_s;
    logic [31:0] skid_ins_r,   skid_ins_nx_s;
    logic [31:0] skid_pc_r,    skid_pc_nx_s;
    logic [31:0] ins_id_r,     ins_id_nx_s;
    logic [31:0] pc_idif_r,    pc_idif_nx_s;
    logic        valid_id_r,   valid_id_nx_s;

    logic        redirect_s;
    logic [31:0] target_s;
    logic        hazard_s;
    logic [31:0] seq_addr_s;
    logic [31:0] link_pc_s;

    ifid_hazard u_hazard (
        .mem_read (MemR_ID),
        .id_valid (valid_id_r),
        .ex_rt    (EX_rfReSel2),
        .id_rs    (ins_id_r[RS_MSB:RS_LSB]),
        .id_rt    (ins_id_r[RT_MSB:RT_LSB]),
        .hazard   (hazard_s)
    );

    // Redirect select (branch beats jump) and sequential address arithmetic.
    always_comb begin
        redirect_s = Branch_taken | Jump_taken;
        if (Branch_taken) begin
            target_s = word_align(Branch_target);
        end else begin
            target_s = word_align(Jump_target);
        end
        seq_addr_s = fetch_addr_r + PC_STEP;
        link_pc_s  = fetch_addr_r + 32'd4;
    end

    // Next-state and datapath decisions for the fetch FSM.
    always_comb begin
        state_nx_s    = state_r;
        fetch_nx_s    = fetch_addr_r;
        pend_nx_s     = pend_addr_r;
        skid_ins_nx_s = skid_ins_r;
        skid_pc_nx_s  = skid_pc_r;
        ins_id_nx_s   = ins_id_r;
        pc_idif_nx_s  = pc_idif_r;
        valid_id_nx_s = valid_id_r;

        if (redirect_s) begin
            ins_id_nx_s   = INS_BUBBLE;
            pc_idif_nx_s  = 32'd0;
            valid_id_nx_s = 1'b0;
        end else begin
            valid_id_nx_s = valid_id_r;
        end

        case (state_r)
            S_FETCH: begin
                if (redirect_s) begin
                    if (imem.Ins_ready) begin
                        fetch_nx_s = target_s;
                    end else begin
                        pend_nx_s  = target_s;
                        state_nx_s = S_DISCARD;
                    end
                end else if (imem.Ins_ready) begin
                    fetch_nx_s = seq_addr_s;
                    if (hazard_s) begin
                        skid_ins_nx_s = imem.Ins_in;
                        skid_pc_nx_s  = link_pc_s;
                        state_nx_s    = S_HOLD;
                    end else begin
                        ins_id_nx_s   = imem.Ins_in;
                        pc_idif_nx_s  = link_pc_s;
                        valid_id_nx_s = 1'b1;
                    end
                end else if (!hazard_s) begin
                    ins_id_nx_s   = INS_BUBBLE;
                    pc_idif_nx_s  = 32'd0;
                    valid_id_nx_s = 1'b0;
                end else begin
                    state_nx_s = S_FETCH;
                end
            end
            S_HOLD: begin
                if (redirect_s) begin
                    fetch_nx_s = target_s;
                    state_nx_s = S_FETCH;
                end else if (!hazard_s) begin
                    ins_id_nx_s   = skid_ins_r;
                    pc_idif_nx_s  = skid_pc_r;
                    valid_id_nx_s = 1'b1;
                    state_nx_s    = S_FETCH;
                end else begin
                    state_nx_s = S_HOLD;
                end
            end
            S_DISCARD: begin
                // The old fetch must complete before the new address is issued.
                if (imem.Ins_ready) begin
                    fetch_nx_s = redirect_s ? target_s : pend_addr_r;
                    state_nx_s = S_FETCH;
                end else if (redirect_s) begin
                    pend_nx_s = target_s;
                end else begin
                    state_nx_s = S_DISCARD;
                end
            end
            default: begin
                state_nx_s = S_FETCH;
            end
        endcase
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_r      <= S_FETCH;
            fetch_addr_r <= RESET_PC;
            pend_addr_r  <= 32'd0;
            skid_ins_r   <= 32'd0;
            skid_pc_r    <= 32'd0;
            ins_id_r     <= INS_BUBBLE;
            pc_idif_r    <= 32'd0;
            valid_id_r   <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            fetch_addr_r <= fetch_nx_s;
            pend_addr_r  <= pend_nx_s;
            skid_ins_r   <= skid_ins_nx_s;
            skid_pc_r    <= skid_pc_nx_s;
            ins_id_r     <= ins_id_nx_s;
            pc_idif_r    <= pc_idif_nx_s;
            valid_id_r   <= valid_id_nx_s;
        end
    end

    assign imem.Ins_req   = (state_r != S_HOLD);
    assign imem.Imem_addr = fetch_addr_r;
    assign Ins_ID         = ins_id_r;
    assign PC_IDIF        = pc_idif_r;
    assign Valid_ID       = valid_id_r;
    assign Nop            = redirect_s | hazard_s;

endmodule
